// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//
// Write-back stage and integer register file for the 64-bit RISC-V pipeline.
// This block consumes the MEM/WB pipeline register outputs and does four jobs:
//   * selects the write-back value (load data or ALU result),
//   * commits that value to a 32 x XLEN register file (x0 hardwired to zero),
//   * serves the two combinational ID-stage read ports,
//   * counts retired register writes and retired load write-backs.
//
// Parameters
//   XLEN   data width of the registers and the write-back path (default 64)
//   CNT_W  width of each retirement counter (default 32)
//
// Ports
//   clk               rising-edge clock
//   reset             synchronous, active-high reset
//   read_data_stored  load data from MEM/WB
//   ALU_Result_stored ALU result from MEM/WB
//   rd_stored         destination register from MEM/WB
//   RegWrite_stored   write enable from MEM/WB
//   MemtoReg_stored   1 = write load data, 0 = write ALU result
//   MemRead_stored    instruction in WB is a load
//   rs1, rs2          ID-stage read addresses
//   ReadData1/2       combinational read values for rs1 / rs2
//   wb_data           selected write-back value (also feeds the forwarding unit)
//   wb_commit         register write takes effect at the next clk edge
//   wr_count          committed register writes (wraps modulo 2^CNT_W)
//   ld_count          committed load write-backs (wraps modulo 2^CNT_W)
//
// Build option
//   WB_BYPASS_EN  when defined, a read of the register being committed in the
//                 same cycle returns wb_data (write-before-read). When
//                 undefined, the read returns the pre-write array value and the
//                 hazard logic upstream must cover the one-cycle gap.
// -----------------------------------------------------------------------------
module wb_regfile #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  read_data_stored,
  input  logic [XLEN-1:0]  ALU_Result_stored,
  input  logic [4:0]       rd_stored,
  input  logic             RegWrite_stored,
  input  logic             MemtoReg_stored,
  input  logic             MemRead_stored,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  output logic [XLEN-1:0]  ReadData1,
  output logic [XLEN-1:0]  ReadData2,
  output logic [XLEN-1:0]  wb_data,
  output logic             wb_commit,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] ld_count
);

  localparam int NUM_PORTS = 2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // x0 has no storage; the array only covers x1..x31.
  logic [XLEN-1:0]  regs_q [1:31];
  logic [CNT_W-1:0] wr_count_q, wr_count_d;
  logic [CNT_W-1:0] ld_count_q, ld_count_d;

  // ---------------------------------------------------------------------------
  // Write-back select and commit qualification
  // ---------------------------------------------------------------------------
  logic ld_commit;

  assign wb_data = MemtoReg_stored ? read_data_stored : ALU_Result_stored;

  // Writes to x0 are dropped here, so they neither touch the array nor count.
  // Gating with ~reset makes reset win over an in-flight write-back.
  assign wb_commit = RegWrite_stored & (rd_stored != 5'd0) & ~reset;

  // A load is only counted when the data actually written is the load data;
  // MemRead without MemtoReg is inconsistent control and writes the ALU value.
  assign ld_commit = wb_commit & MemRead_stored & MemtoReg_stored;

  // ---------------------------------------------------------------------------
  // Retirement counters (wrap naturally at 2^CNT_W)
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_count_d = wr_count_q;
    ld_count_d = ld_count_q;
    if (wb_commit) wr_count_d = wr_count_q + CNT_W'(1);
    if (ld_commit) ld_count_d = ld_count_q + CNT_W'(1);
  end

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_count_q <= '0;
      ld_count_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
      ld_count_q <= ld_count_d;
    end
  end

  assign wr_count = wr_count_q;
  assign ld_count = ld_count_q;

  // ---------------------------------------------------------------------------
  // Register array
  // ---------------------------------------------------------------------------
  // NOTE: this array is deliberately cleared by reset because software may
  // read any register right after reset and must see zero; that choice rules
  // out mapping it onto a plain RAM macro without a clear sequencer.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_commit) begin
      regs_q[rd_stored] <= wb_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  logic [4:0]      rs_addr [NUM_PORTS];
  logic [XLEN-1:0] rd_val  [NUM_PORTS];

  assign rs_addr[0] = rs1;
  assign rs_addr[1] = rs2;

  // NOTE: every output of this block gets a default before any condition, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      rd_val[p] = '0;
      // Reads return 0 while reset is high, even before the first reset edge
      // has cleared the array, and x0 always reads 0.
      if (!reset && (rs_addr[p] != 5'd0)) begin
`ifdef WB_BYPASS_EN
        // wb_commit already excludes rd = 0, so x0 is never forwarded.
        if (wb_commit && (rs_addr[p] == rd_stored)) begin
          rd_val[p] = wb_data;
        end else begin
          rd_val[p] = regs_q[rs_addr[p]];
        end
`else
        rd_val[p] = regs_q[rs_addr[p]];
`endif
      end
    end
  end

  assign ReadData1 = rd_val[0];
  assign ReadData2 = rd_val[1];

endmodule

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile
//
// Self-checking bench for wb_regfile. A behavioural model (plain array plus
// counters) tracks the architectural register file; each scenario task drives
// stimulus and compares the DUT against that model. A second, narrow-counter
// instance shares all inputs so counter wrap-around can be reached quickly.
// Honours WB_BYPASS_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_wb_regfile;

  localparam int XLEN    = 64;
  localparam int CNT_W   = 32;
  localparam int SMALL_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [XLEN-1:0]  read_data_stored;
  logic [XLEN-1:0]  ALU_Result_stored;
  logic [4:0]       rd_stored;
  logic             RegWrite_stored;
  logic             MemtoReg_stored;
  logic             MemRead_stored;
  logic [4:0]       rs1, rs2;
  logic [XLEN-1:0]  ReadData1, ReadData2, wb_data;
  logic             wb_commit;
  logic [CNT_W-1:0] wr_count, ld_count;

  logic [XLEN-1:0]    s_rd1, s_rd2, s_wb;
  logic               s_commit;
  logic [SMALL_W-1:0] s_wr_count, s_ld_count;

  int tests_run    = 0;
  int tests_failed = 0;

  // Behavioural model
  logic [XLEN-1:0] mdl [32];
  int unsigned     mdl_wr;
  int unsigned     mdl_ld;

  always #5 clk = ~clk;

  wb_regfile #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .read_data_stored(read_data_stored), .ALU_Result_stored(ALU_Result_stored),
    .rd_stored(rd_stored), .RegWrite_stored(RegWrite_stored),
    .MemtoReg_stored(MemtoReg_stored), .MemRead_stored(MemRead_stored),
    .rs1(rs1), .rs2(rs2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .wb_data(wb_data),
    .wb_commit(wb_commit), .wr_count(wr_count), .ld_count(ld_count)
  );

  wb_regfile #(.XLEN(XLEN), .CNT_W(SMALL_W)) dut_small (
    .clk(clk), .reset(reset),
    .read_data_stored(read_data_stored), .ALU_Result_stored(ALU_Result_stored),
    .rd_stored(rd_stored), .RegWrite_stored(RegWrite_stored),
    .MemtoReg_stored(MemtoReg_stored), .MemRead_stored(MemRead_stored),
    .rs1(rs1), .rs2(rs2),
    .ReadData1(s_rd1), .ReadData2(s_rd2), .wb_data(s_wb),
    .wb_commit(s_commit), .wr_count(s_wr_count), .ld_count(s_ld_count)
  );

  // ---------------------------------------------------------------------------
  // Model helpers (derived from the block's architectural rules)
  // ---------------------------------------------------------------------------
  function automatic logic [XLEN-1:0] exp_wb();
    return MemtoReg_stored ? read_data_stored : ALU_Result_stored;
  endfunction

  function automatic logic exp_commit();
    return RegWrite_stored && (rd_stored != 5'd0) && !reset;
  endfunction

  function automatic logic [XLEN-1:0] exp_read(input logic [4:0] rs);
    if (reset || rs == 5'd0) return '0;
`ifdef WB_BYPASS_EN
    if (exp_commit() && rs == rd_stored) return exp_wb();
`endif
    return mdl[rs];
  endfunction

  // Apply the effect of the coming clock edge to the model, then advance.
  task automatic tick();
    if (reset) begin
      for (int i = 0; i < 32; i++) mdl[i] = '0;
      mdl_wr = 0;
      mdl_ld = 0;
    end else if (exp_commit()) begin
      mdl[rd_stored] = exp_wb();
      mdl_wr++;
      if (MemRead_stored && MemtoReg_stored) mdl_ld++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic mtr, input logic mr,
                       input logic [4:0] rd, input logic [XLEN-1:0] alu,
                       input logic [XLEN-1:0] ldd,
                       input logic [4:0] a1, input logic [4:0] a2);
    RegWrite_stored   = rw;
    MemtoReg_stored   = mtr;
    MemRead_stored    = mr;
    rd_stored         = rd;
    ALU_Result_stored = alu;
    read_data_stored  = ldd;
    rs1               = a1;
    rs2               = a2;
    #1;
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
    drive(1'b0, 1'b0, 1'b0, 5'd0, '0, '0, a1, a2);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 5'd5, 64'h77, 64'h0, 5'd5, 5'd31);
    tests_run++;
    if (ReadData1 !== '0 || ReadData2 !== '0) begin
      tests_failed++;
      $display("FAIL reset_read_during: rd1=%h rd2=%h expected 0", ReadData1, ReadData2);
    end
    tests_run++;
    if (wb_commit !== 1'b0 || wb_data !== 64'h77) begin
      tests_failed++;
      $display("FAIL reset_wb_outputs: commit=%b wb=%h expected 0 / 77", wb_commit, wb_data);
    end
    tick();
    tick();
    reset = 1'b0;
    idle(5'd5, 5'd31);
    tests_run++;
    if (ReadData1 !== exp_read(5'd5) || ReadData2 !== exp_read(5'd31)) begin
      tests_failed++;
      $display("FAIL reset_read_after: rd1=%h rd2=%h expected 0", ReadData1, ReadData2);
    end
    tests_run++;
    if (wr_count !== 32'd0 || ld_count !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_counters: wr=%0d ld=%0d expected 0/0", wr_count, ld_count);
    end
  endtask

  task automatic test_alu_writeback();
    drive(1'b1, 1'b0, 1'b0, 5'd7, 64'h1234_5678_9ABC_DEF0, 64'hCAFE, 5'd0, 5'd0);
    tests_run++;
    if (wb_data !== 64'h1234_5678_9ABC_DEF0 || wb_commit !== 1'b1) begin
      tests_failed++;
      $display("FAIL alu_wb_select: wb=%h commit=%b expected 123456789abcdef0/1", wb_data, wb_commit);
    end
    tick();
    idle(5'd7, 5'd0);
    tests_run++;
    if (ReadData1 !== 64'h1234_5678_9ABC_DEF0) begin
      tests_failed++;
      $display("FAIL alu_wb_read: got %h expected 123456789abcdef0", ReadData1);
    end
    tests_run++;
    if (wr_count !== 32'd1 || ld_count !== 32'd0) begin
      tests_failed++;
      $display("FAIL alu_wb_counters: wr=%0d ld=%0d expected 1/0", wr_count, ld_count);
    end
  endtask

  task automatic test_load_writeback();
    drive(1'b1, 1'b1, 1'b1, 5'd3, 64'h1111, 64'hFFFF_FFFF_FFFF_FF80, 5'd0, 5'd0);
    tick();
    idle(5'd0, 5'd3);
    tests_run++;
    if (ReadData2 !== 64'hFFFF_FFFF_FFFF_FF80) begin
      tests_failed++;
      $display("FAIL load_wb_read: got %h expected ffffffffffffff80", ReadData2);
    end
    tests_run++;
    if (wr_count !== 32'd2 || ld_count !== 32'd1) begin
      tests_failed++;
      $display("FAIL load_wb_counters: wr=%0d ld=%0d expected 2/1", wr_count, ld_count);
    end
    // Inconsistent control: MemRead without MemtoReg writes ALU, no load count.
    drive(1'b1, 1'b0, 1'b1, 5'd12, 64'hA1A1, 64'hB2B2, 5'd0, 5'd0);
    tick();
    idle(5'd12, 5'd0);
    tests_run++;
    if (ReadData1 !== 64'hA1A1 || wr_count !== 32'd3 || ld_count !== 32'd1) begin
      tests_failed++;
      $display("FAIL inconsistent_ctrl: x12=%h wr=%0d ld=%0d expected a1a1/3/1",
               ReadData1, wr_count, ld_count);
    end
  endtask

  task automatic test_x0();
    drive(1'b1, 1'b0, 1'b0, 5'd0, 64'hDEAD, 64'h0, 5'd0, 5'd0);
    tests_run++;
    if (wb_commit !== 1'b0 || ReadData1 !== '0) begin
      tests_failed++;
      $display("FAIL x0_commit: commit=%b rd1=%h expected 0/0", wb_commit, ReadData1);
    end
    tick();
    idle(5'd0, 5'd0);
    tests_run++;
    if (ReadData1 !== '0 || wr_count !== 32'd3 || ld_count !== 32'd1) begin
      tests_failed++;
      $display("FAIL x0_after: rd1=%h wr=%0d ld=%0d expected 0/3/1", ReadData1, wr_count, ld_count);
    end
  endtask

  task automatic test_same_cycle();
    logic [XLEN-1:0] exp_now;
    drive(1'b1, 1'b0, 1'b0, 5'd9, 64'h11, 64'h0, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 5'd9, 64'hAA, 64'h0, 5'd9, 5'd9);
`ifdef WB_BYPASS_EN
    exp_now = 64'hAA;
`else
    exp_now = 64'h11;
`endif
    tests_run++;
    if (ReadData1 !== exp_now || ReadData2 !== exp_now) begin
      tests_failed++;
      $display("FAIL same_cycle_read: rd1=%h rd2=%h expected %h", ReadData1, ReadData2, exp_now);
    end
    tick();
    idle(5'd9, 5'd0);
    tests_run++;
    if (ReadData1 !== 64'hAA) begin
      tests_failed++;
      $display("FAIL same_cycle_next: got %h expected aa", ReadData1);
    end
  endtask

  task automatic test_reset_collision();
    drive(1'b1, 1'b0, 1'b0, 5'd4, 64'h99, 64'h0, 5'd0, 5'd0);
    tick();
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 5'd4, 64'h0, 64'h55, 5'd4, 5'd0);
    tests_run++;
    if (wb_commit !== 1'b0 || wb_data !== 64'h55 || ReadData1 !== '0) begin
      tests_failed++;
      $display("FAIL reset_collision_during: commit=%b wb=%h rd1=%h expected 0/55/0",
               wb_commit, wb_data, ReadData1);
    end
    tick();
    reset = 1'b0;
    idle(5'd4, 5'd0);
    tests_run++;
    if (ReadData1 !== '0 || wr_count !== 32'd0 || ld_count !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_collision_after: x4=%h wr=%0d ld=%0d expected 0/0/0",
               ReadData1, wr_count, ld_count);
    end
  endtask

  task automatic test_wrap();
    // Narrow instance: 7 commits reach all-ones, the 8th wraps to zero.
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, 1'b1, 5'(i + 1), 64'h0, 64'(i + 100), 5'd0, 5'd0);
      tick();
    end
    idle(5'd0, 5'd0);
    tests_run++;
    if (s_wr_count !== 3'd7 || s_ld_count !== 3'd7) begin
      tests_failed++;
      $display("FAIL wrap_allones: wr=%0d ld=%0d expected 7/7", s_wr_count, s_ld_count);
    end
    drive(1'b1, 1'b1, 1'b1, 5'd20, 64'h0, 64'h5, 5'd0, 5'd0);
    tick();
    idle(5'd0, 5'd0);
    tests_run++;
    if (s_wr_count !== 3'd0 || s_ld_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL wrap_zero: wr=%0d ld=%0d expected 0/0", s_wr_count, s_ld_count);
    end
    tests_run++;
    if (wr_count !== mdl_wr || ld_count !== mdl_ld) begin
      tests_failed++;
      $display("FAIL wrap_wide: wr=%0d ld=%0d expected %0d/%0d", wr_count, ld_count, mdl_wr, mdl_ld);
    end
  endtask

  task automatic test_back_to_back_random();
    logic [4:0] rd;
    for (int n = 0; n < 300; n++) begin
      reset = ($urandom_range(0, 39) == 0);
      rd = 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), rd,
            {$urandom, $urandom}, {$urandom, $urandom},
            ($urandom_range(0, 2) == 0) ? rd : 5'($urandom),
            ($urandom_range(0, 2) == 0) ? rd : 5'($urandom));
      tests_run++;
      if (ReadData1 !== exp_read(rs1) || ReadData2 !== exp_read(rs2)) begin
        tests_failed++;
        $display("FAIL rand_read[%0d]: rs1=%0d got %h exp %h rs2=%0d got %h exp %h", n,
                 rs1, ReadData1, exp_read(rs1), rs2, ReadData2, exp_read(rs2));
      end
      tests_run++;
      if (wb_data !== exp_wb() || wb_commit !== exp_commit()) begin
        tests_failed++;
        $display("FAIL rand_wb[%0d]: wb=%h exp %h commit=%b exp %b", n,
                 wb_data, exp_wb(), wb_commit, exp_commit());
      end
      tick();
      tests_run++;
      if (wr_count !== mdl_wr || ld_count !== mdl_ld ||
          s_wr_count !== SMALL_W'(mdl_wr) || s_ld_count !== SMALL_W'(mdl_ld)) begin
        tests_failed++;
        $display("FAIL rand_count[%0d]: wr=%0d ld=%0d small %0d/%0d exp %0d/%0d", n,
                 wr_count, ld_count, s_wr_count, s_ld_count, mdl_wr, mdl_ld);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    mdl_wr = 0;
    mdl_ld = 0;
    test_reset();
    test_alu_writeback();
    test_load_writeback();
    test_x0();
    test_same_cycle();
    test_reset_collision();
    test_wrap();
    test_back_to_back_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
